// File: rtl/riscv_pkg.sv
// Shared RISC-V immediate-format encodings and per-format immediate range limits.
// B/J maxima are the largest even offsets; their minima are naturally even.
package riscv_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    localparam logic signed [31:0] IMM_IS_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM_IS_MAX =  32'sd2047;
    localparam logic signed [31:0] IMM_B_MIN  = -32'sd4096;
    localparam logic signed [31:0] IMM_B_MAX  =  32'sd4094;
    localparam logic signed [31:0] IMM_J_MIN  = -32'sd1048576;
    localparam logic signed [31:0] IMM_J_MAX  =  32'sd1048574;

endpackage

// File: rtl/imm_pack_fmt.sv
// Scatters a signed immediate into the I/S/B/J fields of an instruction word and flags
// immediates that do not fit; combinational, no latency, no flow control.
module imm_pack_fmt
    import riscv_pkg::*;
(
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  logic [1:0]  src,
    output logic [31:0] instr,
    output logic        err
);

    logic signed [31:0] imm_s;
    assign imm_s = imm;

    always_comb begin
        instr = base;
        err   = 1'b0;
        case (imm_src_e'(src))
            IMM_I: begin
                instr[31:20] = imm[11:0];
                err          = (imm_s < IMM_IS_MIN) || (imm_s > IMM_IS_MAX);
            end
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
                err          = (imm_s < IMM_IS_MIN) || (imm_s > IMM_IS_MAX);
            end
            IMM_B: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
                err          = (imm_s < IMM_B_MIN) || (imm_s > IMM_B_MAX) || imm[0];
            end
            default: begin
                // J format
                instr[31]    = imm[20];
                instr[30:21] = imm[10:1];
                instr[20]    = imm[11];
                instr[19:12] = imm[19:12];
                err          = (imm_s < IMM_J_MIN) || (imm_s > IMM_J_MAX) || imm[0];
            end
        endcase
    end

endmodule

// File: rtl/imm_packer.sv
// Streams instruction words through an immediate packer, tagging each with a word address.
// Latency 2 cycles accept->out_valid; full-rate, in_ready drops only when both stages hold
// data and out_ready is low. IMM_PACKER_ERR_CNT_EN adds a saturating err_cnt output.
module imm_packer
    import riscv_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_base,
    input  logic [31:0]       in_imm,
    input  logic [1:0]        in_imm_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
`ifdef IMM_PACKER_ERR_CNT_EN
    ,
    output logic [15:0]       err_cnt
`endif
);

    logic [31:0]       fmt_instr;
    logic              fmt_err;

    logic              a_vld_q, a_vld_d;
    logic [31:0]       a_instr_q, a_instr_d;
    logic              a_err_q, a_err_d;
    logic              b_vld_q, b_vld_d;
    logic [31:0]       b_instr_q, b_instr_d;
    logic              b_err_q, b_err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              in_acc, b_load, out_fire;

    imm_pack_fmt u_fmt (
        .base  (in_base),
        .imm   (in_imm),
        .src   (in_imm_src),
        .instr (fmt_instr),
        .err   (fmt_err)
    );

    // in_ready is forced low while reset is asserted; clr always advertises ready.
    assign in_ready  = rst_n && (clr || !a_vld_q || !b_vld_q || out_ready);
    assign in_acc    = in_valid && in_ready && !clr;
    assign b_load    = a_vld_q && (!b_vld_q || out_ready);
    assign out_fire  = b_vld_q && out_ready;

    assign out_valid = b_vld_q;
    assign out_instr = b_instr_q;
    assign out_err   = b_err_q;
    assign out_addr  = addr_q;

    always_comb begin
        a_vld_d   = a_vld_q;
        a_instr_d = a_instr_q;
        a_err_d   = a_err_q;
        b_vld_d   = b_vld_q;
        b_instr_d = b_instr_q;
        b_err_d   = b_err_q;
        addr_d    = addr_q;
        if (clr) begin
            a_vld_d   = 1'b0;
            b_vld_d   = 1'b0;
            b_instr_d = '0;
            b_err_d   = 1'b0;
            addr_d    = BASE_ADDR;
        end else begin
            if (out_fire) begin
                b_vld_d = 1'b0;
                addr_d  = addr_q + ADDR_W'(4);
            end
            if (b_load) begin
                b_vld_d   = 1'b1;
                b_instr_d = a_instr_q;
                b_err_d   = a_err_q;
                a_vld_d   = 1'b0;
            end
            if (in_acc) begin
                a_vld_d   = 1'b1;
                a_instr_d = fmt_instr;
                a_err_d   = fmt_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_vld_q   <= 1'b0;
            a_instr_q <= '0;
            a_err_q   <= 1'b0;
            b_vld_q   <= 1'b0;
            b_instr_q <= '0;
            b_err_q   <= 1'b0;
            addr_q    <= BASE_ADDR;
        end else begin
            a_vld_q   <= a_vld_d;
            a_instr_q <= a_instr_d;
            a_err_q   <= a_err_d;
            b_vld_q   <= b_vld_d;
            b_instr_q <= b_instr_d;
            b_err_q   <= b_err_d;
            addr_q    <= addr_d;
        end
    end

`ifdef IMM_PACKER_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr) begin
            err_cnt_d = '0;
        end else if (out_fire && b_err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
